linescanner_capture_controller: RTL

Second-generation linescanner front end. It drives the sensor exposure sequence (rst_cvc, rst_cds, sample) with parameterised hold times, and generates load_pulse after each ADC conversion. It captures pixels into a registered stream with pixel index, line framing and line-length checking. It sits between the sensor pins and the line buffer / image processing chain, all on pixel_clock.

---
 rtl/linescanner_pkg.sv | 31 +++
 rtl/linescanner_wait_timer.sv | 26 ++
 rtl/linescanner_capture_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/linescanner_pkg.sv
// Shared types and constants for the linescanner capture controller.
package linescanner_pkg;

    typedef enum logic [2:0] {
        ExpIdle,
        ExpCvcWait,
        ExpCdsWait,
        ExpAdcWait,
        ExpSampleHigh,
        ExpSampleLow
    } exp_state_e;

    typedef enum logic [1:0] {
        LdIdle,
        LdLval,
        LdDelay,
        LdAdcLow
    } load_state_e;

    // Usable sensor clocks per microsecond at the supported pixel clock rates.
    localparam int unsigned CLOCKS_PER_US_50MHZ = 48;
    localparam int unsigned CLOCKS_PER_US_60MHZ = 58;
    localparam int unsigned CLOCKS_PER_US_70MHZ = 68;

    localparam int unsigned DEFAULT_RST_CDS_HOLD_CLOCKS      = 7;
    localparam int unsigned DEFAULT_SAMPLE_TO_RELEASE_CLOCKS = 6;
    localparam int unsigned DEFAULT_LOAD_DELAY_CLOCKS        = 3;

    localparam int unsigned LINE_COUNT_WIDTH = 16;

endpackage

// File: rtl/linescanner_wait_timer.sv
// Loadable down-counter; done is high once the loaded count has drained to zero.
module linescanner_wait_timer #(
    parameter int unsigned TIMER_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [TIMER_WIDTH-1:0] load_value,
    output logic                   done
);

    logic [TIMER_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/linescanner_capture_controller.sv
// Linescanner exposure sequencer, load strobe generator and pixel capture.
// Optional test pattern input enabled by defining LINESCANNER_TEST_PATTERN_EN.
module linescanner_capture_controller
    import linescanner_pkg::*;
#(
    parameter int unsigned DATA_WIDTH               = 8,
    parameter int unsigned LINE_PIXELS              = 1024,
    parameter int unsigned RST_CVC_HOLD_CLOCKS      = CLOCKS_PER_US_50MHZ,
    parameter int unsigned RST_CDS_HOLD_CLOCKS      = DEFAULT_RST_CDS_HOLD_CLOCKS,
    parameter int unsigned SAMPLE_HIGH_CLOCKS       = CLOCKS_PER_US_50MHZ,
    parameter int unsigned SAMPLE_TO_RELEASE_CLOCKS = DEFAULT_SAMPLE_TO_RELEASE_CLOCKS,
    parameter int unsigned LOAD_DELAY_CLOCKS        = DEFAULT_LOAD_DELAY_CLOCKS,
    parameter int unsigned TIMER_WIDTH              = 8
) (
    input  logic                           pixel_clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [DATA_WIDTH-1:0]          data,
    input  logic                           end_adc,
    input  logic                           lval,
`ifdef LINESCANNER_TEST_PATTERN_EN
    input  logic                           test_pattern,
`endif
    output logic                           rst_cvc,
    output logic                           rst_cds,
    output logic                           sample,
    output logic                           load_pulse,
    output logic [DATA_WIDTH-1:0]          pixel_data,
    output logic                           pixel_valid,
    output logic [$clog2(LINE_PIXELS)-1:0] pixel_index,
    output logic                           line_start,
    output logic                           line_done,
    output logic                           line_error,
    output logic [LINE_COUNT_WIDTH-1:0]    line_count
);

    localparam int unsigned IDX_W = $clog2(LINE_PIXELS);
    localparam int unsigned CNT_W = $clog2(LINE_PIXELS + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LINE_PIXELS);

    // Timers are loaded with N-1 so the exit edge lands exactly N edges after entry.
    localparam logic [TIMER_WIDTH-1:0] CVC_LOAD  = TIMER_WIDTH'(RST_CVC_HOLD_CLOCKS - 1);
    localparam logic [TIMER_WIDTH-1:0] CDS_LOAD  = TIMER_WIDTH'(RST_CDS_HOLD_CLOCKS - 1);
    localparam logic [TIMER_WIDTH-1:0] SH_LOAD   = TIMER_WIDTH'(SAMPLE_HIGH_CLOCKS - 1);
    localparam logic [TIMER_WIDTH-1:0] REL_LOAD  = TIMER_WIDTH'(SAMPLE_TO_RELEASE_CLOCKS - 1);
    localparam logic [TIMER_WIDTH-1:0] LOAD_LOAD = TIMER_WIDTH'(LOAD_DELAY_CLOCKS - 1);

    // Exposure sequencer
    exp_state_e             exp_q, exp_d;
    logic                   rst_cvc_d, rst_cds_d, sample_d;
    logic                   exp_start, exp_done;
    logic [TIMER_WIDTH-1:0] exp_load;

    linescanner_wait_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_exp_timer (
        .clk        (pixel_clock),
        .reset      (reset),
        .start      (exp_start),
        .load_value (exp_load),
        .done       (exp_done)
    );

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            exp_q   <= ExpIdle;
            rst_cvc <= 1'b1;
            rst_cds <= 1'b1;
            sample  <= 1'b0;
        end else begin
            exp_q   <= exp_d;
            rst_cvc <= rst_cvc_d;
            rst_cds <= rst_cds_d;
            sample  <= sample_d;
        end
    end

    always_comb begin
        exp_d     = exp_q;
        rst_cvc_d = rst_cvc;
        rst_cds_d = rst_cds;
        sample_d  = sample;
        exp_start = 1'b0;
        exp_load  = '0;
        unique case (exp_q)
            ExpIdle: if (enable) begin
                rst_cvc_d = 1'b0;
                exp_start = 1'b1;
                exp_load  = CVC_LOAD;
                exp_d     = ExpCvcWait;
            end
            ExpCvcWait: if (exp_done) begin
                rst_cds_d = 1'b0;
                exp_start = 1'b1;
                exp_load  = CDS_LOAD;
                exp_d     = ExpCdsWait;
            end
            ExpCdsWait: if (exp_done) begin
                exp_d = ExpAdcWait;
            end
            ExpAdcWait: if (end_adc) begin
                sample_d  = 1'b1;
                exp_start = 1'b1;
                exp_load  = SH_LOAD;
                exp_d     = ExpSampleHigh;
            end
            ExpSampleHigh: if (exp_done) begin
                sample_d  = 1'b0;
                exp_start = 1'b1;
                exp_load  = REL_LOAD;
                exp_d     = ExpSampleLow;
            end
            ExpSampleLow: if (exp_done) begin
                rst_cvc_d = 1'b1;
                rst_cds_d = 1'b1;
                exp_d     = ExpIdle;
            end
            default: exp_d = ExpIdle;
        endcase
    end

    // Load strobe sequencer
    load_state_e ld_q, ld_d;
    logic        load_pulse_d, ld_start, ld_done;

    linescanner_wait_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_load_timer (
        .clk        (pixel_clock),
        .reset      (reset),
        .start      (ld_start),
        .load_value (LOAD_LOAD),
        .done       (ld_done)
    );

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            ld_q       <= LdIdle;
            load_pulse <= 1'b0;
        end else begin
            ld_q       <= ld_d;
            load_pulse <= load_pulse_d;
        end
    end

    always_comb begin
        ld_d         = ld_q;
        load_pulse_d = 1'b0;
        ld_start     = 1'b0;
        unique case (ld_q)
            LdIdle: if (end_adc) begin
                if (lval) begin
                    ld_d = LdLval;
                end else begin
                    ld_d     = LdDelay;
                    ld_start = 1'b1;
                end
            end
            LdLval: if (!lval) begin
                ld_d     = LdDelay;
                ld_start = 1'b1;
            end
            LdDelay: if (ld_done) begin
                load_pulse_d = 1'b1;
                ld_d         = LdAdcLow;
            end
            LdAdcLow: if (!end_adc) begin
                ld_d = LdIdle;
            end
            default: ld_d = LdIdle;
        endcase
    end

    // Pixel capture and line framing
    logic             lval_q, line_active_q, overlong_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise, in_line, capture, fall;
    logic [DATA_WIDTH-1:0] pix_src;

    // lval_q tracks lval through reset so a line already in progress is not taken as a rise.
    assign rise    = lval & ~lval_q;
    assign in_line = line_active_q | rise;
    assign capture = lval & in_line & (cnt_q < FULL_COUNT);
    assign fall    = line_active_q & ~lval;

`ifdef LINESCANNER_TEST_PATTERN_EN
    assign pix_src = test_pattern ? DATA_WIDTH'(cnt_q[IDX_W-1:0]) : data;
`else
    assign pix_src = data;
`endif

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            lval_q        <= lval;
            line_active_q <= 1'b0;
            overlong_q    <= 1'b0;
            cnt_q         <= '0;
            pixel_data    <= '0;
            pixel_valid   <= 1'b0;
            pixel_index   <= '0;
            line_start    <= 1'b0;
            line_done     <= 1'b0;
            line_error    <= 1'b0;
            line_count    <= '0;
        end else begin
            lval_q      <= lval;
            pixel_valid <= capture;
            line_start  <= capture & (cnt_q == '0);
            line_done   <= fall;
            line_error  <= fall & (overlong_q | (cnt_q != FULL_COUNT));
            if (lval && in_line) begin
                line_active_q <= 1'b1;
                if (!capture) begin
                    overlong_q <= 1'b1;
                end
            end
            if (capture) begin
                pixel_data  <= pix_src;
                pixel_index <= cnt_q[IDX_W-1:0];
                cnt_q       <= cnt_q + 1'b1;
            end
            if (fall) begin
                line_active_q <= 1'b0;
                overlong_q    <= 1'b0;
                cnt_q         <= '0;
                line_count    <= line_count + 1'b1;
            end
        end
    end

endmodule
